// File: rtl/ysyx_25020037_mdu.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on operand
// magnitudes, RADIX_BITS bits per cycle, with sign correction applied in a final fix-up cycle.
module ysyx_25020037_mdu #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RADIX_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned STEPS = XLEN / RADIX_BITS;
  localparam int unsigned CW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic [2:0]          op_q;
  logic                sign1_q, sign2_q;
  logic [XLEN-1:0]     opa_q;
  logic [2*XLEN-1:0]   acc_q;

  logic                is_div, s1_signed, s2_signed, neg1, neg2;
  logic                div_zero, div_ovf, special;
  logic [XLEN-1:0]     mag1, mag2, special_res;

  assign is_div    = op[2];
  assign s1_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
  assign s2_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  assign neg1      = s1_signed & src1[XLEN-1];
  assign neg2      = s2_signed & src2[XLEN-1];
  assign mag1      = neg1 ? -src1 : src1;
  assign mag2      = neg2 ? -src2 : src2;

  assign div_zero = is_div && (src2 == '0);
  assign div_ovf  = ((op == 3'b100) || (op == 3'b110)) &&
                    (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1);
  assign special  = div_zero || div_ovf;

  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = op[1] ? src1 : '1;
    end else if (div_ovf) begin
      special_res = op[1] ? '0 : src1;
    end
  end

  // One iteration cycle: RADIX_BITS unrolled single-bit multiply or divide steps.
  // Multiply: acc = {partial high, remaining multiplier}; divide: acc = {remainder, dividend/quotient}.
  logic [2*XLEN:0]   mt;
  logic [XLEN:0]     dr;
  logic [XLEN-1:0]   dq;
  logic [2*XLEN-1:0] step_acc;

  always_comb begin
    mt = {1'b0, acc_q};
    dr = {1'b0, acc_q[2*XLEN-1:XLEN]};
    dq = acc_q[XLEN-1:0];
    for (int i = 0; i < int'(RADIX_BITS); i++) begin
      if (mt[0]) begin
        mt[2*XLEN:XLEN] = mt[2*XLEN:XLEN] + {1'b0, opa_q};
      end
      mt = mt >> 1;
      dr = {dr[XLEN-1:0], dq[XLEN-1]};
      dq = {dq[XLEN-2:0], 1'b0};
      if (dr >= {1'b0, opa_q}) begin
        dr    = dr - {1'b0, opa_q};
        dq[0] = 1'b1;
      end
    end
    step_acc = op_q[2] ? {dr[XLEN-1:0], dq} : mt[2*XLEN-1:0];
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_res;

  always_comb begin
    prod = (sign1_q ^ sign2_q) ? -acc_q : acc_q;
    quo  = (sign1_q ^ sign2_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = sign1_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (op_q[2]) begin
      fix_res = op_q[1] ? rem : quo;
    end else if (op_q == 3'b000) begin
      fix_res = prod[XLEN-1:0];
    end else begin
      fix_res = prod[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_q      <= '0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      opa_q     <= '0;
      acc_q     <= '0;
      out_valid <= 1'b0;
      result    <= '0;
    end else if (flush) begin
      state_q   <= StIdle;
      out_valid <= 1'b0;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_q    <= op;
            sign1_q <= neg1;
            sign2_q <= neg2;
            opa_q   <= is_div ? mag2 : mag1;
            acc_q   <= {{XLEN{1'b0}}, is_div ? mag1 : mag2};
            if (special) begin
              result    <= special_res;
              out_valid <= 1'b1;
              state_q   <= StDone;
            end else begin
              cnt_q   <= CW'(STEPS);
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          acc_q <= step_acc;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          result    <= fix_res;
          out_valid <= 1'b1;
          state_q   <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready = (state_q == StIdle);
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_ysyx_25020037_mdu.sv
// Directed bench for ysyx_25020037_mdu: one radix-1 and one radix-4 instance, hand-computed vectors.
module tb_ysyx_25020037_mdu;

  logic        clk;
  logic        rst;
  logic        iv  [2];
  logic [2:0]  opv [2];
  logic [31:0] a   [2];
  logic [31:0] b   [2];
  logic        fl  [2];
  logic        ordy[2];
  logic        ir  [2];
  logic        ov  [2];
  logic [31:0] res [2];
  logic        bz  [2];

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_25020037_mdu #(.XLEN(32), .RADIX_BITS(1)) u_r1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .op(opv[0]),
    .src1(a[0]), .src2(b[0]), .flush(fl[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .result(res[0]), .busy(bz[0])
  );

  ysyx_25020037_mdu #(.XLEN(32), .RADIX_BITS(4)) u_r4 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .op(opv[1]),
    .src1(a[1]), .src2(b[1]), .flush(fl[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .result(res[1]), .busy(bz[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one op at the current negedge; returns after the accept edge, inputs scrambled.
  task automatic issue(input int s, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    iv[s] = 1'b1; opv[s] = o; a[s] = x; b[s] = y;
    @(negedge clk);
    iv[s] = 1'b0; opv[s] = 3'($urandom); a[s] = $urandom; b[s] = $urandom;
  endtask

  task automatic wait_valid(input int s, output int lat);
    lat = 0;
    while (!ov[s] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // explat < 0 marks a special case: result must be visible by E0+1.
  task automatic do_op(input int s, input string tag, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp, input int explat);
    int lat;
    issue(s, o, x, y);
    chk({tag, "_inrdy"}, 32'(ir[s]), 32'd0);
    wait_valid(s, lat);
    if (explat < 0) chk({tag, "_lat"}, 32'(lat <= 1), 32'd1);
    else            chk({tag, "_lat"}, 32'(lat), 32'(explat));
    chk({tag, "_res"}, res[s], exp);
  endtask

  task automatic finish_op(input int s, input string tag);
    ordy[s] = 1'b1;
    @(negedge clk);
    ordy[s] = 1'b0;
    chk({tag, "_hs_inrdy"}, 32'(ir[s]), 32'd1);
    chk({tag, "_hs_valid"}, 32'(ov[s]), 32'd0);
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; opv[i] = 3'd0; a[i] = '0; b[i] = '0; fl[i] = 1'b0; ordy[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_inrdy", 32'(ir[i]), 32'd1);
      chk("rst_valid", 32'(ov[i]), 32'd0);
      chk("rst_res",   res[i],     32'd0);
      chk("rst_busy",  32'(bz[i]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    do_op(0, "mul_r1", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33); finish_op(0, "mul_r1");
    do_op(1, "mul_r4", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 9);  finish_op(1, "mul_r4");
    do_op(1, "mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 9); finish_op(1, "mulh");
    do_op(0, "mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33); finish_op(0, "mulhu");
    do_op(1, "mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9); finish_op(1, "mulhsu");
    do_op(1, "mul_ovf", 3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0, 9); finish_op(1, "mul_ovf");

    do_op(0, "div",    3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33); finish_op(0, "div");
    do_op(0, "rem",    3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33); finish_op(0, "rem");
    do_op(1, "div_r4", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 9);  finish_op(1, "div_r4");
    do_op(1, "divu",   3'b101, 32'd100, 32'd7, 32'd14, 9); finish_op(1, "divu");
    do_op(0, "remu",   3'b111, 32'd100, 32'd7, 32'd2, 33); finish_op(0, "remu");

    do_op(0, "div0",    3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, -1); finish_op(0, "div0");
    do_op(0, "remu0",   3'b111, 32'd5, 32'd0, 32'd5, -1);         finish_op(0, "remu0");
    do_op(0, "div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, -1);
    finish_op(0, "div_ovf");
    do_op(1, "rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, -1);
    finish_op(1, "rem_ovf");

    // Backpressure: result held for 10 cycles, then back-to-back DIVU.
    do_op(1, "bp", 3'b101, 32'd1000, 32'd9, 32'd111, 9);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!ov[1] || ir[1] || res[1] !== 32'd111) seen = 1;
    end
    chk("bp_stable", 32'(seen), 32'd0);
    finish_op(1, "bp");
    do_op(1, "b2b_divu", 3'b101, 32'd9, 32'd3, 32'd3, 9); finish_op(1, "b2b_divu");

    // Flush mid-CALC at E0+5.
    issue(0, 3'b000, 32'd5, 32'd6);
    repeat (4) @(negedge clk);
    fl[0] = 1'b1;
    @(negedge clk);
    fl[0] = 1'b0;
    chk("flush_inrdy", 32'(ir[0]), 32'd1);
    chk("flush_busy",  32'(bz[0]), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ov[0]) seen = 1;
    end
    chk("flush_novalid", 32'(seen), 32'd0);
    do_op(0, "post_flush", 3'b000, 32'd3, 32'd4, 32'd12, 33); finish_op(0, "post_flush");

    // Flush in DONE with out_ready and in_valid also high: result dropped, nothing accepted.
    do_op(1, "fdone", 3'b011, 32'd2, 32'd3, 32'd0, 9);
    fl[1] = 1'b1; ordy[1] = 1'b1; iv[1] = 1'b1; opv[1] = 3'b000; a[1] = 32'd1; b[1] = 32'd1;
    @(negedge clk);
    fl[1] = 1'b0; ordy[1] = 1'b0; iv[1] = 1'b0;
    chk("fdone_valid", 32'(ov[1]), 32'd0);
    chk("fdone_inrdy", 32'(ir[1]), 32'd1);
    @(negedge clk);
    chk("fdone_busy", 32'(bz[1]), 32'd0);

    // Asynchronous reset mid-CALC.
    issue(0, 3'b000, 32'd5, 32'd6);
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_inrdy", 32'(ir[0]), 32'd1);
    chk("arst_valid", 32'(ov[0]), 32'd0);
    chk("arst_res",   res[0],     32'd0);
    chk("arst_busy",  32'(bz[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ov[0]) seen = 1;
    end
    chk("arst_novalid", 32'(seen), 32'd0);
    do_op(0, "post_rst", 3'b000, 32'd3, 32'd4, 32'd12, 33); finish_op(0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_25020037_mdu.md
# ysyx_25020037_mdu

Iterative RV32M multiply/divide unit: a parametrised, multi-cycle execute sub-unit beside the single-cycle ALU in the execute stage. It takes one M-extension operation per valid/ready handshake, computes it over XLEN/RADIX_BITS iteration cycles (special divide cases finish early), and holds the result until the downstream stage accepts it. A synchronous flush abandons an in-flight operation, e.g. on redirect.

## Interface
- XLEN, 32, operand/result width; must be even and at least 8.
- RADIX_BITS, 1, multiplier/quotient bits resolved per iteration cycle; legal values are 1, 2 and 4, and the value must divide XLEN.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  an operation is offered.
- in_ready  out  1  unit can accept; high exactly when state is IDLE.
- op  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- src1, src2  in  XLEN each  operands (rs1, rs2).
- flush  in  1  synchronous abort.
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream accepts the result.
- result  out  XLEN  operation result.
- busy  out  1  state is not IDLE.

## Operation
- States:
  - IDLE: accept an operation.
  - CALC: iterate.
  - FIX: apply the sign correction and latch the result.
  - DONE: hold the result.
- Accept: at a rising edge with in_valid & in_ready & !flush, latch op, the operand magnitudes and the sign flags.
  - Special divide cases go straight to DONE with result loaded.
  - Every other operation goes to CALC with the step counter set to STEPS = XLEN/RADIX_BITS.
- Signedness:
  - src1 is signed for MULH, MULHSU, DIV and REM.
  - src2 is signed for MULH, DIV and REM.
  - MUL is computed unsigned, since the low half is sign-independent.
- Multiply: unsigned shift-add over the magnitudes with a 2*XLEN-bit accumulator, consuming RADIX_BITS multiplier bits per cycle. In FIX, negate the product when the operand signs differ. MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
- Divide: restoring division on the magnitudes, producing RADIX_BITS quotient bits per cycle. In FIX:
  - quotient sign = sign1 ^ sign2;
  - remainder sign = sign1.
- Special cases, decided at accept (no CALC):
  - src2 == 0: DIV and DIVU return all ones; REM and REMU return src1.
  - DIV or REM with src1 == 1<<(XLEN-1) and src2 == all ones: DIV returns src1, REM returns 0.
- CALC decrements the counter each cycle. The cycle in which the counter reaches 1 moves to FIX at the next edge.
- FIX moves to DONE at the next edge; result and out_valid become visible after that edge.
- DONE:
  - result and out_valid stay stable while out_ready is low.
  - out_valid & out_ready at an edge returns the unit to IDLE, with out_valid dropping after that edge.
  - No new operation is accepted in the same cycle as the result handshake.
- flush takes priority over every other transition. At the next edge the state becomes IDLE and out_valid becomes 0. A pending result is discarded even if out_ready is high, and in_valid in the same cycle is not accepted.
- Reset, at any point including mid-CALC: state IDLE, out_valid 0, result 0, busy 0, in_ready 1, counter 0, datapath registers 0.

## Timing
- Accept at edge E0:
  - normal operation: out_valid is high after edge E0+STEPS+1 (XLEN=32: E0+33 for RADIX_BITS=1, E0+9 for RADIX_BITS=4);
  - special case: out_valid is high after E0+1.
- in_ready is 0 from after E0 until after the edge that completes the output handshake or flush.
- Minimum issue interval for normal operations: STEPS+3 cycles.
- Outputs are registered or derive from state only; there is no combinational path from in_valid or out_ready to any output.
- Operand, op and sign registers only load at accept; input changes during CALC, FIX or DONE have no effect.

## Test plan
- MUL 7 × 0xFFFFFFFD, XLEN=32, RADIX_BITS=1 -> result 0xFFFFFFEB, out_valid first high after E0+33; repeat with RADIX_BITS=4 -> same result after E0+9.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF; MUL 0x10000×0x10000 -> 0.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM 0xFFFFFFF9%2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100%7 -> 2.
- Special cases, all with out_valid after E0+1: DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result, out_valid=1 and in_ready=0 all stable; then raise out_ready -> IDLE and in_ready=1 after that edge; a back-to-back DIVU 9/3 then returns 3.
- Flush mid-CALC (cycle E0+5), and separately rst asserted mid-CALC -> out_valid never rises for that operation, in_ready=1 after the edge or immediately on rst; the next MUL 3×4 returns 12 with nominal latency.
